piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter N, default 8, word width in bits; the module SHALL support N >= 2.
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 load_valid  input  1  upstream asserts when D holds a word to transmit.
REQ-005 load_ready  output  1  the block can accept a word this cycle.
REQ-006 D  input  N  parallel word; the block SHALL sample it only on handshake.
REQ-007 en  input  1  shift enable from downstream; when low, all state SHALL freeze.
REQ-008 SO  output  1  serial output bit, LSB first; it feeds the downstream shift register's SI.
REQ-009 SO_valid  output  1  SO carries a data bit this cycle.
REQ-010 busy  output  1  the FSM is in SHIFT.
REQ-011 done  output  1  one-cycle pulse coincident with the last bit of a word.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 A handshake SHALL occur on a rising clk edge where load_valid=1 and load_ready=1.
REQ-014 load_ready SHALL equal en & (state==IDLE | (state==SHIFT & cnt==N-1)); it is combinational and SHALL NOT depend on load_valid.
REQ-015 On a handshake, the block SHALL load D into shift register q_reg[N-1:0], set counter cnt to 0, and enter or remain in SHIFT.
REQ-016 In SHIFT: SO = q_reg[0] and SO_valid = 1.
REQ-017 In SHIFT with en=1 and cnt<N-1, each edge SHALL apply q_reg <= {1'b0, q_reg[N-1:1]} and cnt <= cnt+1.
REQ-018 In SHIFT with en=1, cnt==N-1 and no handshake, the next state SHALL be IDLE.
REQ-019 In SHIFT with en=1, cnt==N-1 and a handshake, the block SHALL reload as per REQ-015, so words stream with no idle gap between them.
REQ-020 done SHALL be 1 exactly when state==SHIFT, cnt==N-1 and en=1; it is a single-cycle pulse per word.
REQ-021 In IDLE: SO=0, SO_valid=0, busy=0, done=0.
REQ-022 With en=0, q_reg, cnt and state SHALL hold; SO and SO_valid SHALL hold their values; done=0 and load_ready=0.
REQ-023 The latency from a handshake edge to bit 0 on SO SHALL be one cycle; a word SHALL occupy exactly N en-high cycles.
REQ-024 cnt SHALL be $clog2(N) bits wide and SHALL never exceed N-1.
REQ-025 The block SHALL ignore load_valid while load_ready=0; a held request SHALL be accepted at the next ready cycle.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: state=IDLE, q_reg=0, cnt=0, SO=0, SO_valid=0, busy=0, done=0.
REQ-027 A reset asserted mid-word SHALL abort the word with no further bits output; after release the block SHALL be in IDLE with load_ready=en.
REQ-028 Release of reset SHALL take effect at the first rising clk edge after reset_n goes high; no handshake SHALL be accepted while reset_n=0.

Verification (N=8)
REQ-029 Scenario: reset, en=1, one handshake with D=8'hA5 -> SO over the next 8 cycles = 1,0,1,0,0,1,0,1 with SO_valid=1; done high on the 8th cycle only; IDLE with SO_valid=0 on the 9th cycle.
REQ-030 Scenario: load_valid held high, D=8'hA5 then 8'h3C -> 16 contiguous SO_valid cycles, bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; two done pulses at cycles 8 and 16.
REQ-031 Scenario: D=8'hFF, en dropped for 3 cycles after bit 2 -> SO holds 1, SO_valid holds 1, done=0 during the stall; total SO_valid span = 11 cycles; still exactly 8 distinct bits.
REQ-032 Scenario: reset_n pulsed low asynchronously (mid-cycle) during bit 4 of 8'hA5 -> SO=0 and SO_valid=0 immediately; no done pulse; the next word 8'h01 serializes as 1,0,0,0,0,0,0,0.
REQ-033 Scenario: load_valid=1 while busy with cnt<7 -> load_ready=0, D changes are ignored, and the new word is accepted only at cnt==7.
REQ-034 Scenario: en=0 in IDLE with load_valid=1 -> no handshake, SO_valid stays 0; en rising -> accepted next edge.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out word serializer, LSB first
// Words are accepted on a valid/ready handshake and shifted out one bit per en-high cycle.
module piso_serializer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [N-1:0] D,
   input  logic         en,
   output logic         SO,
   output logic         SO_valid,
   output logic         busy,
   output logic         done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   q_reg;
   logic [N-1:0]   q_nxt;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic           at_last;
   logic           handshake;

   assign at_last    = (state == SHIFT) && (cnt == LAST);
   // Ready on the last bit lets back-to-back words stream without a gap.
   assign load_ready = en & ((state == IDLE) | at_last);
   assign handshake  = load_valid & load_ready;

   assign SO       = (state == SHIFT) & q_reg[0];
   assign SO_valid = (state == SHIFT);
   assign busy     = (state == SHIFT);
   assign done     = at_last & en;

   always_comb begin
      state_nxt = state;
      q_nxt     = q_reg;
      cnt_nxt   = cnt;
      if (handshake) begin
         state_nxt = SHIFT;
         q_nxt     = D;
         cnt_nxt   = '0;
      end else if (en && (state == SHIFT)) begin
         if (at_last) begin
            state_nxt = IDLE;
            q_nxt     = '0;
            cnt_nxt   = '0;
         end else begin
            q_nxt   = {1'b0, q_reg[N-1:1]};
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         q_reg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         q_reg <= q_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule
